// File: rtl/exmem_hazard_forward_unit_pkg.sv
// exmem_hazard_forward_unit_pkg: shared pipeline constants and FSM state encoding
package exmem_hazard_forward_unit_pkg;
    localparam int REG_ADDR_W = 5;
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;
endpackage

// File: rtl/exmem_hazard_forward_unit_if.sv
// exmem_hazard_forward_unit_if: pipeline stage fields in, hazard/forward controls out
interface exmem_hazard_forward_unit_if #(
    parameter int REG_ADDR_W  = exmem_hazard_forward_unit_pkg::REG_ADDR_W,
    parameter int STALL_CNT_W = 16
);
    logic [REG_ADDR_W-1:0]  id_rs1;
    logic [REG_ADDR_W-1:0]  id_rs2;
    logic [REG_ADDR_W-1:0]  idex_rs1;
    logic [REG_ADDR_W-1:0]  idex_rs2;
    logic [REG_ADDR_W-1:0]  idex_rd;
    logic                   idex_mem_read;
    logic                   branch_taken;
    logic [REG_ADDR_W-1:0]  exmem_rd;
    logic                   exmem_reg_write;
    logic                   exmem_mem_read;
    logic                   exmem_mem_req;
    logic                   mem_ready;
    logic [REG_ADDR_W-1:0]  memwb_rd;
    logic                   memwb_reg_write;
    logic [1:0]             forward_a;
    logic [1:0]             forward_b;
    logic                   stall_pc;
    logic                   stall_ifid;
    logic                   stall_idex;
    logic                   stall_exmem;
    logic                   bubble_idex;
    logic                   bubble_memwb;
    logic                   flush_ifid;
    logic                   mem_error;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, idex_mem_read, branch_taken,
               exmem_rd, exmem_reg_write, exmem_mem_read, exmem_mem_req, mem_ready,
               memwb_rd, memwb_reg_write,
        input  forward_a, forward_b, stall_pc, stall_ifid, stall_idex, stall_exmem,
               bubble_idex, bubble_memwb, flush_ifid, mem_error, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, idex_mem_read, branch_taken,
               exmem_rd, exmem_reg_write, exmem_mem_read, exmem_mem_req, mem_ready,
               memwb_rd, memwb_reg_write,
        output forward_a, forward_b, stall_pc, stall_ifid, stall_idex, stall_exmem,
               bubble_idex, bubble_memwb, flush_ifid, mem_error, stall_count
    );
endinterface

// File: rtl/exmem_hazard_forward_unit_forward_select.sv
// exmem_hazard_forward_unit_forward_select: ALU operand bypass select for one source register
module exmem_hazard_forward_unit_forward_select
    import exmem_hazard_forward_unit_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] idex_rs,
    input  logic [ADDR_W-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic              exmem_mem_read,
    input  logic [ADDR_W-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    output logic [1:0]        sel
);
    // EX/MEM wins over MEM/WB; loads in EX/MEM have no data yet; x0 is never bypassed
    always_comb begin
        sel = (exmem_reg_write && !exmem_mem_read && exmem_rd != '0 && exmem_rd == idex_rs) ? FWD_EXMEM :
              (memwb_reg_write && memwb_rd != '0 && memwb_rd == idex_rs) ? FWD_MEMWB : FWD_RF;
    end
endmodule

// File: rtl/exmem_hazard_forward_unit.sv
// exmem_hazard_forward_unit: forwarding, load-use/flush control and memory-wait freeze FSM
module exmem_hazard_forward_unit #(
    parameter int REG_ADDR_W  = exmem_hazard_forward_unit_pkg::REG_ADDR_W,
    parameter int WAIT_LIMIT  = 8,
    parameter int STALL_CNT_W = 16
) (
    input logic                          clk,
    input logic                          reset,
    exmem_hazard_forward_unit_if.slave   bus
);
    import exmem_hazard_forward_unit_pkg::*;

    localparam int WCW = $clog2(WAIT_LIMIT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);

    state_t                 state;
    logic [WCW-1:0]         wait_cnt;
    logic [STALL_CNT_W-1:0] cnt;
    logic                   err;
    logic [1:0]             fa;
    logic [1:0]             fb;
    logic                   freeze;
    logic                   flush;
    logic                   load_use;
    logic                   stall;

    exmem_hazard_forward_unit_forward_select #(.ADDR_W(REG_ADDR_W)) u_fwd_a (
        .idex_rs(bus.idex_rs1), .exmem_rd(bus.exmem_rd), .exmem_reg_write(bus.exmem_reg_write),
        .exmem_mem_read(bus.exmem_mem_read), .memwb_rd(bus.memwb_rd),
        .memwb_reg_write(bus.memwb_reg_write), .sel(fa)
    );

    exmem_hazard_forward_unit_forward_select #(.ADDR_W(REG_ADDR_W)) u_fwd_b (
        .idex_rs(bus.idex_rs2), .exmem_rd(bus.exmem_rd), .exmem_reg_write(bus.exmem_reg_write),
        .exmem_mem_read(bus.exmem_mem_read), .memwb_rd(bus.memwb_rd),
        .memwb_reg_write(bus.memwb_reg_write), .sel(fb)
    );

    // Freeze outranks flush, which outranks load-use (a squashed ID instruction needs no stall)
    always_comb begin
        freeze = state == ERROR || (state == MEM_WAIT && !bus.mem_ready) ||
                 (state == RUN && bus.exmem_mem_req && !bus.mem_ready);
        flush = !freeze && bus.branch_taken;
        load_use = !freeze && !bus.branch_taken && bus.idex_mem_read && bus.idex_rd != '0 &&
                   (bus.idex_rd == bus.id_rs1 || bus.idex_rd == bus.id_rs2);
        stall = reset && (freeze || load_use);
    end

    // Drive controls; everything reads zero while reset is held low
    always_comb begin
        bus.forward_a    = reset ? fa : FWD_RF;
        bus.forward_b    = reset ? fb : FWD_RF;
        bus.stall_pc     = stall;
        bus.stall_ifid   = stall;
        bus.stall_idex   = reset && freeze;
        bus.stall_exmem  = reset && freeze;
        bus.bubble_memwb = reset && freeze;
        bus.bubble_idex  = reset && (flush || load_use);
        bus.flush_ifid   = reset && flush;
        bus.mem_error    = reset && err;
        bus.stall_count  = reset ? cnt : '0;
    end

    // Memory-wait FSM with timeout into a sticky error state, plus saturating stall counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            cnt      <= '0;
            err      <= 1'b0;
        end else begin
            if (stall && cnt != '1)
                cnt <= cnt + 1'b1;
            case (state)
                RUN: begin
                    if (bus.exmem_mem_req && !bus.mem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WCW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt >= WAIT_LAST) begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: err <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_exmem_hazard_forward_unit.sv
// tb_exmem_hazard_forward_unit: vector table for forwarding/hazards plus freeze, timeout and saturation sequences
module tb_exmem_hazard_forward_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_pass = 0;
    int   n_tot = 0;

    always #5 clk = ~clk;

    exmem_hazard_forward_unit_if #(.REG_ADDR_W(5), .STALL_CNT_W(4)) bus ();

    exmem_hazard_forward_unit #(.REG_ADDR_W(5), .WAIT_LIMIT(8), .STALL_CNT_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd;
        logic       idex_mr, br;
        logic [4:0] ex_rd;
        logic       ex_rw, ex_mr;
        logic [4:0] wb_rd;
        logic       wb_rw;
        logic [1:0] fa, fb;
        logic       stall, bub, flush;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.idex_rs1 = '0; bus.idex_rs2 = '0; bus.idex_rd = '0;
        bus.idex_mem_read = 0; bus.branch_taken = 0; bus.exmem_rd = '0; bus.exmem_reg_write = 0;
        bus.exmem_mem_read = 0; bus.exmem_mem_req = 0; bus.mem_ready = 0;
        bus.memwb_rd = '0; bus.memwb_reg_write = 0;
    endtask

    task automatic reset_seq();
        @(negedge clk);
        reset = 0;
        idle();
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd3, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd3, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{5'd0, 5'd0, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{5'd0, 5'd0, 5'd6, 5'd9, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 5'd9, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{5'd7, 5'd2, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{5'd3, 5'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{5'd0, 5'd0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0};

        // Reset holds every output at zero even with active inputs
        idle();
        bus.exmem_rd = 5'd5; bus.exmem_reg_write = 1; bus.idex_rs1 = 5'd5;
        bus.branch_taken = 1; bus.exmem_mem_req = 1;
        @(negedge clk);
        #1;
        chk("rst_forward_a", 32'(bus.forward_a), 0);
        chk("rst_stall_pc", 32'(bus.stall_pc), 0);
        chk("rst_flush_ifid", 32'(bus.flush_ifid), 0);
        chk("rst_bubble_memwb", 32'(bus.bubble_memwb), 0);
        chk("rst_mem_error", 32'(bus.mem_error), 0);
        chk("rst_stall_count", 32'(bus.stall_count), 0);
        @(negedge clk);
        reset = 1;
        idle();

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bus.id_rs1 = vecs[i].id_rs1; bus.id_rs2 = vecs[i].id_rs2;
            bus.idex_rs1 = vecs[i].idex_rs1; bus.idex_rs2 = vecs[i].idex_rs2; bus.idex_rd = vecs[i].idex_rd;
            bus.idex_mem_read = vecs[i].idex_mr; bus.branch_taken = vecs[i].br;
            bus.exmem_rd = vecs[i].ex_rd; bus.exmem_reg_write = vecs[i].ex_rw; bus.exmem_mem_read = vecs[i].ex_mr;
            bus.memwb_rd = vecs[i].wb_rd; bus.memwb_reg_write = vecs[i].wb_rw;
            #1;
            chk($sformatf("v%0d_forward_a", i), 32'(bus.forward_a), 32'(vecs[i].fa));
            chk($sformatf("v%0d_forward_b", i), 32'(bus.forward_b), 32'(vecs[i].fb));
            chk($sformatf("v%0d_stall_pc", i), 32'(bus.stall_pc), 32'(vecs[i].stall));
            chk($sformatf("v%0d_stall_ifid", i), 32'(bus.stall_ifid), 32'(vecs[i].stall));
            chk($sformatf("v%0d_bubble_idex", i), 32'(bus.bubble_idex), 32'(vecs[i].bub));
            chk($sformatf("v%0d_flush_ifid", i), 32'(bus.flush_ifid), 32'(vecs[i].flush));
            chk($sformatf("v%0d_stall_exmem", i), 32'(bus.stall_exmem), 0);
        end

        // Load-use stall lasts one cycle and counts once; a same-cycle branch suppresses it
        reset_seq();
        bus.idex_mem_read = 1; bus.idex_rd = 5'd7; bus.id_rs2 = 5'd7;
        #1;
        chk("lu_stall_pc", 32'(bus.stall_pc), 1);
        chk("lu_stall_idex", 32'(bus.stall_idex), 0);
        @(negedge clk);
        bus.idex_mem_read = 0; bus.idex_rd = '0;
        #1;
        chk("lu_after_stall_pc", 32'(bus.stall_pc), 0);
        chk("lu_stall_count", 32'(bus.stall_count), 1);
        bus.idex_mem_read = 1; bus.idex_rd = 5'd7; bus.branch_taken = 1;
        #1;
        chk("lubr_flush_ifid", 32'(bus.flush_ifid), 1);
        chk("lubr_stall_pc", 32'(bus.stall_pc), 0);
        @(negedge clk);
        #1;
        chk("lubr_stall_count", 32'(bus.stall_count), 1);

        // Memory wait of three cycles, branch ignored while frozen and honoured on release
        reset_seq();
        bus.exmem_mem_req = 1; bus.mem_ready = 0;
        #1;
        chk("mw_stall_exmem", 32'(bus.stall_exmem), 1);
        chk("mw_bubble_memwb", 32'(bus.bubble_memwb), 1);
        @(negedge clk);
        bus.branch_taken = 1;
        #1;
        chk("mw_br_stall_pc", 32'(bus.stall_pc), 1);
        chk("mw_br_flush_ifid", 32'(bus.flush_ifid), 0);
        chk("mw_br_bubble_idex", 32'(bus.bubble_idex), 0);
        @(negedge clk);
        #1;
        chk("mw_stall_idex", 32'(bus.stall_idex), 1);
        @(negedge clk);
        bus.mem_ready = 1;
        #1;
        chk("mw_rel_stall_pc", 32'(bus.stall_pc), 0);
        chk("mw_rel_stall_exmem", 32'(bus.stall_exmem), 0);
        chk("mw_rel_flush_ifid", 32'(bus.flush_ifid), 1);
        chk("mw_rel_stall_count", 32'(bus.stall_count), 3);
        @(negedge clk);
        bus.exmem_mem_req = 0; bus.mem_ready = 1; bus.branch_taken = 0;
        #1;
        chk("mw_ready_noreq_freeze", 32'(bus.bubble_memwb), 0);
        chk("mw_after_stall_count", 32'(bus.stall_count), 3);
        bus.exmem_mem_req = 1;
        #1;
        chk("mw_run_hit_freeze", 32'(bus.stall_exmem), 0);

        // Timeout into sticky error, saturating counter, then reset clears everything
        reset_seq();
        bus.exmem_mem_req = 1; bus.mem_ready = 0;
        repeat (7) @(negedge clk);
        #1;
        chk("to_pre_mem_error", 32'(bus.mem_error), 0);
        chk("to_pre_stall_count", 32'(bus.stall_count), 7);
        @(negedge clk);
        #1;
        chk("to_mem_error", 32'(bus.mem_error), 1);
        chk("to_stall_count", 32'(bus.stall_count), 8);
        bus.mem_ready = 1;
        #1;
        chk("err_stall_pc", 32'(bus.stall_pc), 1);
        chk("err_stall_exmem", 32'(bus.stall_exmem), 1);
        repeat (10) @(negedge clk);
        #1;
        chk("sat_stall_count", 32'(bus.stall_count), 15);
        chk("sat_mem_error", 32'(bus.mem_error), 1);
        reset = 0;
        #1;
        chk("rst2_stall_pc", 32'(bus.stall_pc), 0);
        chk("rst2_mem_error", 32'(bus.mem_error), 0);
        chk("rst2_bubble_memwb", 32'(bus.bubble_memwb), 0);
        chk("rst2_stall_count", 32'(bus.stall_count), 0);
        @(negedge clk);
        reset = 1;
        idle();
        #1;
        chk("post_stall_count", 32'(bus.stall_count), 0);
        chk("post_mem_error", 32'(bus.mem_error), 0);
        chk("post_stall_pc", 32'(bus.stall_pc), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
